// File: rtl/state_dump_scanner_pkg.sv
// Shared encodings for the state-dump scanner: scope modes, record source codes, FSM states.
// Pure definitions, no timing or flow-control behaviour of its own.
package dump_pkg;

   localparam logic [1:0] SCOPE_BOTH = 2'b00;
   localparam logic [1:0] SCOPE_REGS = 2'b01;
   localparam logic [1:0] SCOPE_MEM  = 2'b10;

   localparam logic SRC_REG = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REGS  = 2'd1,
      ST_MEM   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/state_dump_scanner_if.sv
// Scanner control, read-port and record-stream bundle; master = scanner, slave = host side.
// Record stream is valid/ready; read ports are combinational (data same cycle as address).
interface state_dump_scanner_if #(
   parameter int XLEN      = 32,
   parameter int N_REGS    = 32,
   parameter int MEM_DEPTH = 32,
   parameter int RA_W      = $clog2(N_REGS),
   parameter int MA_W      = $clog2(MEM_DEPTH),
   parameter int IDX_W     = dump_pkg::max_w(RA_W, MA_W)
);

   logic             start;
   logic [1:0]       scope;
   logic             skip_zero;
   logic             busy;
   logic             done;
   logic [RA_W-1:0]  reg_raddr;
   logic [XLEN-1:0]  reg_rdata;
   logic [MA_W-1:0]  mem_raddr;
   logic [XLEN-1:0]  mem_rdata;
   logic             out_valid;
   logic             out_ready;
   logic             out_src;
   logic [IDX_W-1:0] out_index;
   logic [XLEN-1:0]  out_data;

   modport master (
      input  start, scope, skip_zero, reg_rdata, mem_rdata, out_ready,
      output busy, done, reg_raddr, mem_raddr, out_valid, out_src, out_index, out_data
   );

   modport slave (
      output start, scope, skip_zero, reg_rdata, mem_rdata, out_ready,
      input  busy, done, reg_raddr, mem_raddr, out_valid, out_src, out_index, out_data
   );

endinterface

// File: rtl/state_dump_scanner_out_stage.sv
// Single-entry valid/ready record register; loads in the same cycle the slot is free.
// Backpressure: fields hold while valid && !ready; a load with keep_i=0 leaves valid low.
module dump_out_stage #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             keep_i,
   input  logic             src_i,
   input  logic [IDX_W-1:0] index_i,
   input  logic [XLEN-1:0]  data_i,
   input  logic             ready_i,
   output logic             slot_o,
   output logic             valid_o,
   output logic             src_o,
   output logic [IDX_W-1:0] index_o,
   output logic [XLEN-1:0]  data_o
);

   logic             valid_q, valid_d;
   logic             src_q, src_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [XLEN-1:0]  data_q, data_d;

   always_comb begin
      slot_o  = !valid_q || ready_i;
      valid_d = valid_q;
      src_d   = src_q;
      index_d = index_q;
      data_d  = data_q;
      if (load_i && slot_o) begin
         valid_d = keep_i;
         src_d   = src_i;
         index_d = index_i;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         src_q   <= 1'b0;
         index_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         src_q   <= src_d;
         index_q <= index_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign src_o   = src_q;
   assign index_o = index_q;
   assign data_o  = data_q;

endmodule

// File: rtl/state_dump_scanner.sv
// Debug readout: walks register bank then data memory, one {src,index,data} record per word.
// Latency: start at edge k gives first record in cycle k+1; 1 record/cycle; stalls while out_ready low.
module state_dump_scanner
   import dump_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int N_REGS    = 32,
   parameter int MEM_DEPTH = 32,
   parameter int RA_W      = $clog2(N_REGS),
   parameter int MA_W      = $clog2(MEM_DEPTH),
   parameter int IDX_W     = max_w(RA_W, MA_W)
) (
   input logic                  clk,
   input logic                  reset,
   state_dump_scanner_if.master bus
);

   localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(N_REGS - 1);
   localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       scope_q, scope_d;
   logic             skip_q, skip_d;
   logic             done_q, done_d;

   logic             slot;
   logic             load;
   logic             ld_src;
   logic             ld_keep;
   logic [XLEN-1:0]  ld_data;
   logic [RA_W-1:0]  reg_raddr;
   logic [MA_W-1:0]  mem_raddr;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      scope_d   = scope_q;
      skip_d    = skip_q;
      done_d    = 1'b0;
      load      = 1'b0;
      ld_src    = SRC_REG;
      ld_data   = bus.reg_rdata;
      reg_raddr = '0;
      mem_raddr = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               scope_d = bus.scope;
               skip_d  = bus.skip_zero;
               idx_d   = '0;
               state_d = (bus.scope == SCOPE_MEM) ? ST_MEM : ST_REGS;
            end
         end
         ST_REGS: begin
            reg_raddr = RA_W'(idx_q);
            load      = 1'b1;
            if (slot) begin
               if (idx_q == REG_LAST) begin
                  idx_d   = '0;
                  // Both encodings 00 and 11 continue into memory.
                  state_d = (scope_q == SCOPE_REGS) ? ST_DRAIN : ST_MEM;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_MEM: begin
            mem_raddr = MA_W'(idx_q);
            load      = 1'b1;
            ld_src    = SRC_MEM;
            ld_data   = bus.mem_rdata;
            if (slot) begin
               if (idx_q == MEM_LAST) begin
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Leave once the final record has been taken (or was suppressed).
            if (!bus.out_valid || bus.out_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ld_keep = !(skip_q && (ld_data == '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         scope_q <= SCOPE_BOTH;
         skip_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         scope_q <= scope_d;
         skip_q  <= skip_d;
         done_q  <= done_d;
      end
   end

   dump_out_stage #(
      .XLEN  (XLEN),
      .IDX_W (IDX_W)
   ) u_out (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .keep_i  (ld_keep),
      .src_i   (ld_src),
      .index_i (idx_q),
      .data_i  (ld_data),
      .ready_i (bus.out_ready),
      .slot_o  (slot),
      .valid_o (bus.out_valid),
      .src_o   (bus.out_src),
      .index_o (bus.out_index),
      .data_o  (bus.out_data)
   );

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.reg_raddr = reg_raddr;
   assign bus.mem_raddr = mem_raddr;

endmodule
